// File: rtl/painel_pkg.sv
// Shared types and defaults for the panel receiver: row count, default geometry
// and the 5-bit column word.
package painel_pkg;
  localparam int NROW     = 5;
  localparam int NCOL_DEF = 16;
  localparam int DIV_DEF  = 1000;

  typedef logic [NROW-1:0] col_t;

  // Counter width that stays at least one bit for degenerate sizes of 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/painel_receptor_varredura_colunas.sv
// Column scanner: prescales clk by DIV, steps the active column index and
// registers the one-hot active-low column select.
module varredura_colunas
  import painel_pkg::*;
#(
  parameter int NCOL = NCOL_DEF,
  parameter int DIV  = DIV_DEF,
  localparam int CW  = cnt_w(NCOL),
  localparam int PW  = cnt_w(DIV)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [CW-1:0]   scan_col,
  output logic [NCOL-1:0] col_n
);
  logic [PW-1:0]   pre_cnt_q, pre_cnt_d;
  logic [CW-1:0]   scan_col_q, scan_col_d;
  logic [NCOL-1:0] col_n_q, col_n_d;

  always_comb begin
    pre_cnt_d  = pre_cnt_q + PW'(1);
    scan_col_d = scan_col_q;
    if (pre_cnt_q == PW'(DIV - 1)) begin
      pre_cnt_d  = '0;
      scan_col_d = (scan_col_q == CW'(NCOL - 1)) ? '0 : scan_col_q + CW'(1);
    end
  end

  for (genvar gi = 0; gi < NCOL; gi++) begin : g_decode
    assign col_n_d[gi] = (scan_col_q != CW'(gi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q  <= '0;
      scan_col_q <= '0;
      col_n_q    <= '1;
    end else begin
      pre_cnt_q  <= pre_cnt_d;
      scan_col_q <= scan_col_d;
      col_n_q    <= col_n_d;
    end
  end

  assign scan_col = scan_col_q;
  assign col_n    = col_n_q;
endmodule

// File: rtl/painel_receptor.sv
// Panel receiver: assembles serial row columns into a frame, commits complete
// frames atomically to the display buffer and drives the scanned LED matrix.
module painel_receptor
  import painel_pkg::*;
#(
  parameter int NCOL = NCOL_DEF,
  parameter int DIV  = DIV_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NROW-1:0] inRU,
  input  logic            valid,
  input  logic            sync,
  output logic            frame_done,
  output logic [NCOL-1:0] col_n,
  output logic [NROW-1:0] row
);
  localparam int CW = cnt_w(NCOL);

  col_t cap_q [NCOL];
  col_t cap_d [NCOL];
  col_t shifted [NCOL];
  col_t disp_q [NCOL];
  col_t disp_d [NCOL];
  logic [CW-1:0] cap_cnt_q, cap_cnt_d;
  logic [CW-1:0] scan_col;
  logic          commit;
  logic          frame_done_q;
  col_t          row_q, row_d;

  // Capture shift: new column enters at the right, older ones move toward 0.
  for (genvar gi = 0; gi < NCOL - 1; gi++) begin : g_shift
    assign shifted[gi] = cap_q[gi+1];
  end
  assign shifted[NCOL-1] = inRU;

  always_comb begin
    commit    = valid && (cap_cnt_q == CW'(NCOL - 1)) && (!sync || (NCOL == 1));
    cap_d     = cap_q;
    disp_d    = disp_q;
    cap_cnt_d = cap_cnt_q;
    if (valid) cap_d = shifted;
    if (commit) begin
      disp_d    = shifted;
      cap_cnt_d = '0;
    end else if (sync) begin
      cap_cnt_d = valid ? CW'(1) : '0;
    end else if (valid) begin
      cap_cnt_d = cap_cnt_q + CW'(1);
    end
    row_d = disp_q[scan_col];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCOL; i++) begin
        cap_q[i]  <= '0;
        disp_q[i] <= '0;
      end
      cap_cnt_q    <= '0;
      frame_done_q <= 1'b0;
      row_q        <= '0;
    end else begin
      cap_q        <= cap_d;
      disp_q       <= disp_d;
      cap_cnt_q    <= cap_cnt_d;
      frame_done_q <= commit;
      row_q        <= row_d;
    end
  end

  varredura_colunas #(.NCOL(NCOL), .DIV(DIV)) u_varredura (
    .clk      (clk),
    .rst_n    (rst_n),
    .scan_col (scan_col),
    .col_n    (col_n)
  );

  assign frame_done = frame_done_q;
  assign row        = row_q;
endmodule

// File: tb/tb_painel_receptor.sv
// Bench for painel_receptor: directed scenarios with random column data, checked
// every cycle against a frame-queue / scan-time model of the panel.
module tb_painel_receptor;
  import painel_pkg::*;

  localparam int NCOL = 16;
  localparam int DIV  = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [NROW-1:0] inRU = '0;
  logic            valid = 1'b0;
  logic            sync = 1'b0;
  logic            frame_done;
  logic [NCOL-1:0] col_n;
  logic [NROW-1:0] row;

  always #5 clk = ~clk;

  painel_receptor #(.NCOL(NCOL), .DIV(DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inRU       (inRU),
    .valid      (valid),
    .sync       (sync),
    .frame_done (frame_done),
    .col_n      (col_n),
    .row        (row)
  );

  int   checks = 0;
  int   passed = 0;
  int   fails  = 0;
  int   k      = 0;   // edges since reset release
  int   pulses = 0;   // frame_done pulses seen on the DUT
  int   p0;
  col_t q [$];        // columns of the frame being received
  col_t disp [NCOL];  // frame currently committed for display

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, k);
    end
  endtask

  task automatic step(input logic v, input logic s, input col_t d);
    col_t            exp_row;
    logic [NCOL-1:0] exp_col;
    logic            cm;
    int              sc;
    valid = v;
    sync  = s;
    inRU  = v ? d : col_t'($urandom);
    @(posedge clk);
    k++;
    sc      = ((k - 1) / DIV) % NCOL;
    exp_row = disp[sc];
    exp_col = ~(NCOL'(1) << sc);
    if (s) q.delete();
    if (v) q.push_back(d);
    cm = 1'b0;
    if (q.size() == NCOL) begin
      cm = 1'b1;
      for (int i = 0; i < NCOL; i++) disp[i] = q[i];
      q.delete();
      $display("edge %0d: frame committed, col0=%h col15=%h", k, disp[0], disp[NCOL-1]);
    end
    #1;
    if (frame_done === 1'b1) pulses++;
    check("frame_done", frame_done, cm);
    check("col_n", col_n, exp_col);
    check("row", row, exp_row);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_col_n", col_n, {NCOL{1'b1}});
    check("rst_row", row, 0);
    check("rst_frame_done", frame_done, 0);
    q.delete();
    for (int i = 0; i < NCOL; i++) disp[i] = '0;
    k = 0;
    valid = 1'b0;
    sync  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    $display("reset released at %0t", $time);
  endtask

  initial begin
    #3;
    do_reset();

    // Idle scan: one full refresh plus a bit, blank rows.
    p0 = pulses;
    repeat (70) step(1'b0, 1'b0, '0);
    check("idle_pulses", pulses - p0, 0);

    // Contiguous frame, column k carries k.
    p0 = pulses;
    for (int i = 0; i < NCOL; i++) step(1'b1, 1'b0, col_t'(i % 32));
    repeat (70) step(1'b0, 1'b0, '0);
    check("ramp_pulses", pulses - p0, 1);

    // Partial frame discarded by sync; sync column becomes column 0.
    p0 = pulses;
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, col_t'($urandom));
    step(1'b1, 1'b1, 5'h1F);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0, col_t'($urandom));
    repeat (70) step(1'b0, 1'b0, '0);
    check("sync_pulses", pulses - p0, 1);

    // Two frames back to back without a gap.
    p0 = pulses;
    for (int i = 0; i < NCOL; i++) step(1'b1, 1'b0, 5'h0A);
    for (int i = 0; i < NCOL; i++) step(1'b1, 1'b0, 5'h15);
    repeat (70) step(1'b0, 1'b0, '0);
    check("b2b_pulses", pulses - p0, 2);

    // Asynchronous reset mid-frame, then a fresh frame.
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, col_t'($urandom));
    do_reset();
    p0 = pulses;
    for (int i = 0; i < NCOL; i++) step(1'b1, 1'b0, col_t'($urandom));
    repeat (70) step(1'b0, 1'b0, '0);
    check("post_reset_pulses", pulses - p0, 1);

    // Gapped valid: one on, three off.
    p0 = pulses;
    for (int i = 0; i < NCOL; i++) begin
      step(1'b1, 1'b0, col_t'(i % 32));
      repeat (3) step(1'b0, 1'b0, '0);
    end
    repeat (70) step(1'b0, 1'b0, '0);
    check("gapped_pulses", pulses - p0, 1);

    // Random traffic with occasional sync.
    repeat (400) step(1'($urandom % 2), ($urandom % 40) == 0, col_t'($urandom));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
